// File: rtl/sub_serial.sv
// ---------------------------------------------------------------------------
// sub_serial -- bit-serial subtractor, Diff = A - B - Bin (mod 2^WIDTH).
//
// One bit per RUN cycle, LSB first, using a single full-subtractor cell and a
// borrow flop. Operands are captured on an accepted start. Results are held
// in output registers that only change on completion.
//
// Parameters
//   WIDTH  operand/result width (2..32)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  begin a subtraction (ignored while busy)
//   A, B   minuend / subtrahend, captured on accept
//   Bin    borrow-in, captured on accept
//   busy   high while bits are being processed (RUN)
//   done   one-cycle pulse when Diff/Bout/Zero are freshly valid
//   Diff   A - B - Bin
//   Bout   borrow-out, 1 when A < B + Bin (unsigned)
//   Zero   1 when Diff == 0
//   Ovf    signed overflow (only with SUB_SERIAL_OVF_EN defined)
//
// Build option: define SUB_SERIAL_OVF_EN to add the Ovf port and its logic.
//
// Timing: start accepted at edge E0; bits are processed on E1..E(WIDTH);
// the FSM sits in DONE for one cycle and the output registers (and done)
// are loaded on the edge that leaves DONE, so done is visible WIDTH+1
// cycles after the accept edge.
// ---------------------------------------------------------------------------
module sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;     // minuend, shifted right each RUN cycle
    logic [WIDTH-1:0] b_sh;     // subtrahend, shifted right each RUN cycle
    logic [WIDTH-1:0] dsr;      // difference, bits enter at the MSB
    logic             br;       // running borrow
    logic             accept;
    logic             last;
    logic             d_bit;
    logic             br_nxt;

`ifdef SUB_SERIAL_OVF_EN
    // Operand sign bits are shifted out of a_sh/b_sh, so keep them aside.
    logic a_msb;
    logic b_msb;
`endif

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d_bit  = a_sh[0] ^ b_sh[0] ^ br;
        br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    nxt    = RUN;
                end
            end
            RUN: begin
                if (last) nxt = DONE;
            end
            DONE: begin
                // start here chains straight into the next RUN.
                if (start) begin
                    accept = 1'b1;
                    nxt    = RUN;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            dsr  <= '0;
            br   <= 1'b0;
            done <= 1'b0;
            Diff <= '0;
            Bout <= 1'b0;
            Zero <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            Ovf   <= 1'b0;
`endif
        end else begin
            done <= (state == DONE);

            // Results only move here, so partial sums are never visible.
            if (state == DONE) begin
                Diff <= dsr;
                Bout <= br;
                Zero <= (dsr == '0);
`ifdef SUB_SERIAL_OVF_EN
                Ovf  <= (a_msb ^ b_msb) & (a_msb ^ dsr[WIDTH-1]);
`endif
            end

            if (accept) begin
                a_sh <= A;
                b_sh <= B;
                br   <= Bin;
                cnt  <= '0;
`ifdef SUB_SERIAL_OVF_EN
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
`endif
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                br   <= br_nxt;
                dsr  <= {d_bit, dsr[WIDTH-1:1]};
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule
